// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that packs a byte stream into little-endian
// 32-bit words, writes them to instruction memory at consecutive addresses,
// and holds the core in reset until the whole program has been written.
module imem_loader #(
    parameter int unsigned I_ADDR_BITS = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [I_ADDR_BITS:0]   word_count,
    input  logic                   s_valid,
    input  logic [7:0]             s_data,
    output logic                   s_ready,
    output logic                   imem_we,
    output logic [I_ADDR_BITS-1:0] imem_addr,
    output logic [31:0]            imem_wdata,
    output logic                   core_rst_n,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned CNT_W = I_ADDR_BITS + 1;
    localparam int unsigned DEPTH = 1 << I_ADDR_BITS;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [1:0]       byte_cnt;
    logic [23:0]      byte_buf;
    logic [CNT_W-1:0] word_idx;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_clamped;
    logic [CNT_W-1:0] idx_next;
    logic             byte_acc;

    // Handshake and status decoded straight from the state register
    assign s_ready = (state == LOAD);
    assign busy    = (state == LOAD) || (state == WRITE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; word index is one bit wider than the address so a
    // full-memory count compares without wrapping
    always_comb begin
        next_state    = state;
        count_clamped = (word_count > DEPTH_CNT) ? DEPTH_CNT : word_count;
        idx_next      = word_idx + CNT_W'(1);
        byte_acc      = s_valid && (state == LOAD);
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (count_clamped == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (byte_acc && (byte_cnt == 2'd3)) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                next_state = (idx_next == count_q) ? DONE : LOAD;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs, all keyed off the upcoming state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            done       <= 1'b0;
            core_rst_n <= 1'b0;
            byte_cnt   <= 2'd0;
            byte_buf   <= '0;
            word_idx   <= '0;
            count_q    <= '0;
        end else begin
            imem_we <= (next_state == WRITE);
            done    <= (next_state == DONE);

            if ((state == IDLE) && start) begin
                count_q    <= count_clamped;
                byte_cnt   <= 2'd0;
                word_idx   <= '0;
                core_rst_n <= 1'b0;
            end

            // Release the core as the load completes (wins over a zero-count start)
            if (next_state == DONE) begin
                core_rst_n <= 1'b1;
            end

            if (byte_acc) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: byte_buf[7:0]   <= s_data;
                    2'd1: byte_buf[15:8]  <= s_data;
                    2'd2: byte_buf[23:16] <= s_data;
                    default: begin
                        imem_wdata <= {s_data, byte_buf};
                        imem_addr  <= word_idx[I_ADDR_BITS-1:0];
                    end
                endcase
            end

            if (state == WRITE) begin
                word_idx <= idx_next;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: random programs streamed with and without stalls,
// checked against expected write lists and cycle counts computed from the
// loader's documented timing.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  word_count;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [5:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  byte_q[$];
    logic [31:0] exp_w[$];

    imem_loader #(.I_ADDR_BITS(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Memory-side monitor: every write the memory would capture
    always @(posedge clk) begin
        if (imem_we === 1'b1) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
        end
    end

    // Expected output bundle while in reset: {s_ready,imem_we,busy,done,core_rst_n,addr,wdata}
    localparam logic [42:0] RST_VEC = 43'd0;

    // Streams exp_w as bytes; returns the done cycle (relative to the start edge)
    // and counts of cycles where busy/core_rst_n misbehaved before done
    task automatic load_words(input int wc, input bit stall, output int done_t,
                              output int busy_low, output int rstn_hi, output int done_cnt);
        int stall_cnt;
        stall_cnt = 0;
        done_t = -1; busy_low = 0; rstn_hi = 0; done_cnt = 0;
        byte_q.delete();
        for (int i = 0; i < exp_w.size(); i++)
            for (int k = 0; k < 4; k++) byte_q.push_back(exp_w[i][8*k +: 8]);
        wa_q.delete();
        wd_q.delete();
        @(negedge clk);
        start = 1'b1; word_count = 7'(wc);
        s_valid = 1'b1; s_data = 8'hFF;      // must not be consumed in IDLE
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 4000; t++) begin
            if (done === 1'b1) begin
                done_cnt++;
                if (done_t < 0) done_t = t;
            end else if (done_t < 0) begin
                if (busy !== 1'b1) busy_low++;
                if (core_rst_n !== 1'b0) rstn_hi++;
            end
            if (done_t >= 0 && t >= done_t + 3) break;
            if (stall_cnt > 0) begin
                s_valid = 1'b0;
                stall_cnt--;
            end else if (byte_q.size() > 0) begin
                s_valid = 1'b1;
                s_data  = byte_q[0];
                if (s_ready === 1'b1) begin
                    void'(byte_q.pop_front());
                    if (stall) stall_cnt = 2;
                end
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({s_ready, imem_we, busy, done, core_rst_n, imem_addr, imem_wdata} !== RST_VEC) begin
            bad++;
            $display("FAIL reset_values: got %h want %h",
                     {s_ready, imem_we, busy, done, core_rst_n, imem_addr, imem_wdata}, RST_VEC);
        end
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1; word_count = 7'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if (core_rst_n !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_release: core_rst_n got %b want 1", core_rst_n);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({s_ready, imem_we, busy, done, core_rst_n, imem_addr, imem_wdata} !== RST_VEC) begin
            bad++;
            $display("FAIL reset_async: got %h want %h",
                     {s_ready, imem_we, busy, done, core_rst_n, imem_addr, imem_wdata}, RST_VEC);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        int dt, bl, rh, dc;
        exp_w = '{32'h00100513};
        load_words(1, 1'b0, dt, bl, rh, dc);
        total++;
        if (dt !== 5) begin bad++; $display("FAIL single_done_cycle: got %0d want 5", dt); end
        total++;
        if (dc !== 1) begin bad++; $display("FAIL single_done_pulses: got %0d want 1", dc); end
        total++;
        if (bl + rh !== 0) begin bad++; $display("FAIL single_busy_rstn: busy_low=%0d rstn_hi=%0d want 0", bl, rh); end
        total++;
        if (wa_q.size() !== 1) begin
            bad++; $display("FAIL single_write_count: got %0d want 1", wa_q.size());
        end else begin
            total++;
            if (wa_q[0] !== 6'd0 || wd_q[0] !== 32'h00100513) begin
                bad++;
                $display("FAIL single_write: got addr %0d data %h want addr 0 data 00100513", wa_q[0], wd_q[0]);
            end
        end
        total++;
        if (core_rst_n !== 1'b1) begin bad++; $display("FAIL single_core_rst_n: got %b want 1", core_rst_n); end
    endtask

    task automatic test_three_stalls();
        int dt, bl, rh, dc;
        exp_w.delete();
        for (int i = 0; i < 3; i++) exp_w.push_back($urandom);
        load_words(3, 1'b1, dt, bl, rh, dc);
        total++;
        if (dt !== 35) begin bad++; $display("FAIL stall_done_cycle: got %0d want 35", dt); end
        total++;
        if (bl + rh !== 0 || dc !== 1) begin
            bad++; $display("FAIL stall_status: busy_low=%0d rstn_hi=%0d pulses=%0d want 0 0 1", bl, rh, dc);
        end
        total++;
        if (wa_q.size() !== 3) begin
            bad++; $display("FAIL stall_write_count: got %0d want 3", wa_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (wa_q[i] !== 6'(i) || wd_q[i] !== exp_w[i]) begin
                    bad++;
                    $display("FAIL stall_write%0d: got addr %0d data %h want addr %0d data %h",
                             i, wa_q[i], wd_q[i], i, exp_w[i]);
                end
            end
        end
    endtask

    // wc may exceed the depth; the loader must still write exactly 64 words
    task automatic full_load(input int wc, input bit ramp, input string tag);
        int dt, bl, rh, dc;
        exp_w.delete();
        for (int i = 0; i < 64; i++) exp_w.push_back(ramp ? 32'(i) * 32'h01010101 : $urandom);
        load_words(wc, 1'b0, dt, bl, rh, dc);
        total++;
        if (dt !== 320 || dc !== 1 || bl !== 0 || rh !== 0) begin
            bad++;
            $display("FAIL %s_timing: done_t=%0d pulses=%0d busy_low=%0d rstn_hi=%0d want 320 1 0 0",
                     tag, dt, dc, bl, rh);
        end
        total++;
        if (wa_q.size() !== 64) begin
            bad++; $display("FAIL %s_write_count: got %0d want 64", tag, wa_q.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                total++;
                if (wa_q[i] !== 6'(i) || wd_q[i] !== exp_w[i]) begin
                    bad++;
                    $display("FAIL %s_write%0d: got addr %0d data %h want addr %0d data %h",
                             tag, i, wa_q[i], wd_q[i], i, exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_full_memory();
        full_load(64, 1'b1, "full");
        full_load($urandom_range(65, 127), 1'b0, "clamp");
    endtask

    task automatic test_random_loads();
        int dt, bl, rh, dc, n, want_t;
        bit st;
        for (int it = 0; it < 4; it++) begin
            n  = $urandom_range(1, 10);
            st = 1'($urandom_range(0, 1));
            exp_w.delete();
            for (int i = 0; i < n; i++) exp_w.push_back($urandom);
            load_words(n, st, dt, bl, rh, dc);
            want_t = st ? 12 * n - 1 : 5 * n;
            total++;
            if (dt !== want_t || dc !== 1 || bl !== 0 || rh !== 0) begin
                bad++;
                $display("FAIL rand%0d_timing: done_t=%0d pulses=%0d busy_low=%0d rstn_hi=%0d want %0d 1 0 0",
                         it, dt, dc, bl, rh, want_t);
            end
            total++;
            if (wa_q.size() !== n) begin
                bad++; $display("FAIL rand%0d_write_count: got %0d want %0d", it, wa_q.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    total++;
                    if (wa_q[i] !== 6'(i) || wd_q[i] !== exp_w[i]) begin
                        bad++;
                        $display("FAIL rand%0d_write%0d: got addr %0d data %h want addr %0d data %h",
                                 it, i, wa_q[i], wd_q[i], i, exp_w[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_zero_count();
        @(negedge clk);
        wa_q.delete(); wd_q.delete();
        start = 1'b1; word_count = 7'd0;
        @(negedge clk);
        total++;
        if (done !== 1'b1 || core_rst_n !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_done: done=%b core_rst_n=%b busy=%b want 1 1 0", done, core_rst_n, busy);
        end
        word_count = 7'd3;                    // start held through DONE must be ignored
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0 || core_rst_n !== 1'b1) begin
            bad++;
            $display("FAIL zero_ignore_start: busy=%b s_ready=%b done=%b core_rst_n=%b want 0 0 0 1",
                     busy, s_ready, done, core_rst_n);
        end
        repeat (2) @(negedge clk);
        total++;
        if (wa_q.size() !== 0) begin bad++; $display("FAIL zero_no_write: got %0d writes want 0", wa_q.size()); end
    endtask

    task automatic test_reset_mid_load();
        int n, dt, bl, rh, dc;
        logic [31:0] w;
        exp_w.delete();
        for (int i = 0; i < 4; i++) exp_w.push_back($urandom);
        byte_q.delete();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) byte_q.push_back(exp_w[i][8*k +: 8]);
        wa_q.delete(); wd_q.delete();
        @(negedge clk);
        start = 1'b1; word_count = 7'd4; s_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int t = 0; t < 100 && n < 6; t++) begin
            s_valid = 1'b1;
            s_data  = byte_q[0];
            if (s_ready === 1'b1) begin
                void'(byte_q.pop_front());
                n++;
            end
            if (n < 6) @(negedge clk);
        end
        @(posedge clk);
        #2 s_valid = 1'b0; rst = 1'b1;
        #1;
        total++;
        if ({s_ready, imem_we, busy, done, core_rst_n, imem_addr, imem_wdata} !== RST_VEC) begin
            bad++;
            $display("FAIL midreset_values: got %h want %h",
                     {s_ready, imem_we, busy, done, core_rst_n, imem_addr, imem_wdata}, RST_VEC);
        end
        total++;
        if (wa_q.size() !== 1 || wd_q[0] !== exp_w[0]) begin
            bad++; $display("FAIL midreset_first_word: got %0d writes want 1 with data %h", wa_q.size(), exp_w[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        w = $urandom;
        exp_w = '{w};
        load_words(1, 1'b0, dt, bl, rh, dc);
        total++;
        if (dt !== 5 || wa_q.size() !== 1) begin
            bad++; $display("FAIL midreset_reload: done_t=%0d writes=%0d want 5 1", dt, wa_q.size());
        end else begin
            total++;
            if (wa_q[0] !== 6'd0 || wd_q[0] !== w) begin
                bad++;
                $display("FAIL midreset_reload_word: got addr %0d data %h want addr 0 data %h", wa_q[0], wd_q[0], w);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; word_count = '0; s_valid = 1'b0; s_data = '0;
        test_reset();
        test_single_word();
        test_three_stalls();
        test_full_memory();
        test_zero_count();
        test_random_loads();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
